// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory request sequencer.
//   MEM_ADDR_W / MEM_DATA_W : default memory geometry (32 x 8)
//   mem_req_t               : one buffered request (write flag, address, write data)
//   ctrl_state_e            : sequencer FSM states
package mem_ctrl_pkg;

  localparam int unsigned MEM_ADDR_W = 5;
  localparam int unsigned MEM_DATA_W = 8;

  typedef struct packed {
    logic                  write;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/mem_req_fifo.sv
// In-order synchronous FIFO of mem_req_t entries.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push, wdata : enqueue request (ignored when full)
//   pop, rdata  : dequeue head (ignored when empty); rdata shows the head
//   full, empty : occupancy flags derived from level
//   level       : current number of stored entries
// No fall-through: a pushed entry is visible at the head the cycle after.
module mem_req_fifo
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  mem_req_t         wdata,
  input  logic             pop,
  output mem_req_t         rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  mem_req_t         store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = store[rd_ptr];

  // Storage needs no reset; validity is tracked by level.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      store[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Request sequencer in front of a synchronous 32x8 memory.
//   clk, rst_n                       : clock, asynchronous active-low reset
//   req_valid/req_ready              : request channel (write flag, addr, wdata)
//   rsp_valid/rsp_ready              : read response channel (rdata, addr)
//   read, write, addr, data_in       : registered memory pins, one-cycle strobes
//   data_out                         : memory read data
//   fifo_level, busy                 : occupancy and activity status
// Requests are executed strictly in order; read and write never overlap.
module mem_req_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = MEM_ADDR_W,
  parameter int unsigned DATA_W     = MEM_DATA_W,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RD_LATENCY = 1,
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              busy
);

  // Wide enough to hold RD_LATENCY even when it is 0.
  localparam int unsigned CNT_W = $clog2(RD_LATENCY + 2);

  ctrl_state_e      state;
  ctrl_state_e      state_d;
  logic [CNT_W-1:0] lat_cnt;
  logic             ready_q;

  mem_req_t         push_req;
  mem_req_t         head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  logic             issue_wr;
  logic             issue_rd;
  logic             capture;
  logic             accept;

  // ready_q holds req_ready low during reset and for the release edge.
  assign req_ready = ready_q && !fifo_full;
  assign push      = req_valid && req_ready;
  assign pop       = issue_wr || issue_rd;
  assign accept    = rsp_valid && rsp_ready;
  assign busy      = !fifo_empty || (state != IDLE);

  always_comb begin
    push_req       = '0;
    push_req.write = req_write;
    push_req.addr  = req_addr;
    push_req.wdata = req_wdata;
  end

  mem_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_req),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Writes behind an outstanding response may proceed because the read has
  // already completed at the memory; a head read must wait for the consumer.
  always_comb begin
    state_d  = state;
    issue_wr = 1'b0;
    issue_rd = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          if (head.write) begin
            issue_wr = 1'b1;
          end else begin
            issue_rd = 1'b1;
            state_d  = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (lat_cnt == CNT_W'(RD_LATENCY)) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (accept) begin
          state_d = IDLE;
          if (!fifo_empty) begin
            if (head.write) begin
              issue_wr = 1'b1;
            end else begin
              issue_rd = 1'b1;
              state_d  = RD_WAIT;
            end
          end
        end else if (!fifo_empty && head.write) begin
          issue_wr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      state   <= IDLE;
      lat_cnt <= '0;
    end else begin
      ready_q <= 1'b1;
      state   <= state_d;
      if (issue_rd) begin
        lat_cnt <= '0;
      end else if (state == RD_WAIT) begin
        lat_cnt <= lat_cnt + 1'b1;
      end
    end
  end

  // Memory pins: strobes follow the issue decision for one cycle only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read    <= 1'b0;
      write   <= 1'b0;
      addr    <= '0;
      data_in <= '0;
    end else begin
      read  <= issue_rd;
      write <= issue_wr;
      if (pop) begin
        addr <= head.addr;
      end
      if (issue_wr) begin
        data_in <= head.wdata;
      end
    end
  end

  // addr still holds the read address at capture: nothing issues in RD_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_addr  <= '0;
    end else if (capture) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= data_out;
      rsp_addr  <= addr;
    end else if (accept) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed self-checking bench for mem_req_ctrl with a behavioural 32x8
// synchronous memory (one-edge read latency). Inputs change and outputs are
// sampled on the falling clock edge.
module tb_mem_req_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [4:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic [4:0] rsp_addr;
  logic       read;
  logic       write;
  logic [4:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [2:0] fifo_level;
  logic       busy;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic        both_seen   = 1'b0;

  logic [7:0] mem [32];
  logic [4:0] wrap_addr [6] = '{5'd1, 5'd7, 5'd13, 5'd19, 5'd25, 5'd31};
  logic [7:0] wrap_data [6] = '{8'h5A, 8'hC3, 8'h01, 8'hFE, 8'h77, 8'h9B};

  mem_req_ctrl #(
    .ADDR_W     (5),
    .DATA_W     (8),
    .FIFO_DEPTH (4),
    .RD_LATENCY (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_addr   (rsp_addr),
    .read       (read),
    .write      (write),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .fifo_level (fifo_level),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write) mem[addr] <= data_in;
    if (read)  data_out  <= mem[addr];
  end

  always @(negedge clk) begin
    if (read && write) both_seen <= 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    data_out  = 8'h00;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_read",      32'(read), 32'd0);
    check("rst_write",     32'(write), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_level",     32'(fifo_level), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_req_ready", 32'(req_ready), 32'd1);

    // Single write: strobe one cycle, two edges after acceptance
    drive(1'b1, 5'd5, 8'hA5);
    @(negedge clk);
    req_valid = 1'b0;
    check("w1_pre_write", 32'(write), 32'd0);
    check("w1_level1",    32'(fifo_level), 32'd1);
    @(negedge clk);
    check("w1_write",   32'(write), 32'd1);
    check("w1_addr",    32'(addr), 32'd5);
    check("w1_data_in", 32'(data_in), 32'hA5);
    check("w1_read",    32'(read), 32'd0);
    check("w1_level0",  32'(fifo_level), 32'd0);
    @(negedge clk);
    check("w1_write_off", 32'(write), 32'd0);

    // Read back: response two edges after the read strobe
    rsp_ready = 1'b1;
    drive(1'b0, 5'd5, 8'h00);
    @(negedge clk);
    req_valid = 1'b0;
    check("r1_pre_read", 32'(read), 32'd0);
    @(negedge clk);
    check("r1_read",  32'(read), 32'd1);
    check("r1_addr",  32'(addr), 32'd5);
    check("r1_write", 32'(write), 32'd0);
    @(negedge clk);
    check("r1_read_off", 32'(read), 32'd0);
    check("r1_rsp_early", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("r1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("r1_rsp_rdata", 32'(rsp_rdata), 32'hA5);
    check("r1_rsp_addr",  32'(rsp_addr), 32'd5);
    @(negedge clk);
    check("r1_rsp_done", 32'(rsp_valid), 32'd0);
    check("r1_busy",     32'(busy), 32'd0);

    // Fill the FIFO behind a held read response
    rsp_ready = 1'b0;
    drive(1'b0, 5'd5, 8'h00);
    @(negedge clk);
    check("f_level1", 32'(fifo_level), 32'd1);
    drive(1'b0, 5'd5, 8'h00);
    @(negedge clk);
    drive(1'b1, 5'd8, 8'h11);
    @(negedge clk);
    drive(1'b1, 5'd9, 8'h22);
    @(negedge clk);
    drive(1'b1, 5'd10, 8'h33);
    @(negedge clk);
    drive(1'b1, 5'd11, 8'h44);
    check("f_full_ready", 32'(req_ready), 32'd0);
    check("f_full_level", 32'(fifo_level), 32'd4);
    check("f_rsp_valid",  32'(rsp_valid), 32'd1);
    check("f_rsp_rdata",  32'(rsp_rdata), 32'hA5);
    @(negedge clk);
    check("f_hold_level", 32'(fifo_level), 32'd4);
    check("f_hold_ready", 32'(req_ready), 32'd0);
    check("f_stall_read", 32'(read), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("f_rd2_read",  32'(read), 32'd1);
    check("f_rd2_rspv",  32'(rsp_valid), 32'd0);
    check("f_rd2_ready", 32'(req_ready), 32'd1);
    check("f_rd2_level", 32'(fifo_level), 32'd3);
    @(negedge clk);
    req_valid = 1'b0;
    check("f_5th_level", 32'(fifo_level), 32'd4);
    @(negedge clk);
    check("f_rsp2_valid", 32'(rsp_valid), 32'd1);
    check("f_rsp2_rdata", 32'(rsp_rdata), 32'hA5);
    @(negedge clk);
    check("f_w8_rspv",  32'(rsp_valid), 32'd0);
    check("f_w8_write", 32'(write), 32'd1);
    check("f_w8_addr",  32'(addr), 32'd8);
    check("f_w8_data",  32'(data_in), 32'h11);
    check("f_w8_level", 32'(fifo_level), 32'd3);
    repeat (3) @(negedge clk);
    check("f_w11_write", 32'(write), 32'd1);
    check("f_w11_addr",  32'(addr), 32'd11);
    check("f_w11_data",  32'(data_in), 32'h44);
    check("f_w11_level", 32'(fifo_level), 32'd0);
    @(negedge clk);
    check("f_idle_busy", 32'(busy), 32'd0);

    // Held response at addr 31; writes 0..2 issue during RESP
    rsp_ready = 1'b0;
    drive(1'b1, 5'd31, 8'h3C);
    @(negedge clk);
    drive(1'b0, 5'd31, 8'h00);
    @(negedge clk);
    drive(1'b1, 5'd0, 8'h10);
    @(negedge clk);
    drive(1'b1, 5'd1, 8'h11);
    @(negedge clk);
    drive(1'b1, 5'd2, 8'h12);
    @(negedge clk);
    drive(1'b0, 5'd0, 8'h00);
    check("h_rsp_valid", 32'(rsp_valid), 32'd1);
    check("h_rsp_rdata", 32'(rsp_rdata), 32'h3C);
    check("h_rsp_addr",  32'(rsp_addr), 32'd31);
    @(negedge clk);
    req_valid = 1'b0;
    check("h_w0_write", 32'(write), 32'd1);
    check("h_w0_addr",  32'(addr), 32'd0);
    check("h_w0_data",  32'(data_in), 32'h10);
    @(negedge clk);
    check("h_w1_addr", 32'(addr), 32'd1);
    check("h_w1_write", 32'(write), 32'd1);
    @(negedge clk);
    check("h_w2_addr", 32'(addr), 32'd2);
    check("h_w2_data", 32'(data_in), 32'h12);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("h_stall_read", 32'(read), 32'd0);
      check("h_stall_rspv", 32'(rsp_valid), 32'd1);
      check("h_stall_data", 32'(rsp_rdata), 32'h3C);
      check("h_stall_lvl",  32'(fifo_level), 32'd1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("h_rd0_read", 32'(read), 32'd1);
    check("h_rd0_addr", 32'(addr), 32'd0);
    check("h_rd0_rspv", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("h_rd0_valid", 32'(rsp_valid), 32'd1);
    check("h_rd0_rdata", 32'(rsp_rdata), 32'h10);
    check("h_rd0_raddr", 32'(rsp_addr), 32'd0);
    @(negedge clk);
    check("h_done_busy", 32'(busy), 32'd0);

    // Wrap-around: alternating write/read pairs through the FIFO
    fork
      begin
        bit acc;
        bit ok;
        for (int i = 0; i < 12; i++) begin
          drive((i % 2) == 0, wrap_addr[i / 2], wrap_data[i / 2]);
          ok = 1'b0;
          for (int t = 0; t < 50 && !ok; t++) begin
            acc = req_ready;
            @(negedge clk);
            if (acc) ok = 1'b1;
          end
          check("wrap_push", 32'(ok), 32'd1);
        end
        req_valid = 1'b0;
      end
      begin
        bit got;
        for (int k = 0; k < 6; k++) begin
          got = 1'b0;
          for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
          end
          check("wrap_rsp_seen", 32'(got), 32'd1);
          check("wrap_rdata", 32'(rsp_rdata), 32'(wrap_data[k]));
          check("wrap_raddr", 32'(rsp_addr), 32'(wrap_addr[k]));
        end
      end
    join
    repeat (3) @(negedge clk);
    check("wrap_busy", 32'(busy), 32'd0);

    // Reset during RD_WAIT
    drive(1'b0, 5'd7, 8'h00);
    @(negedge clk);
    drive(1'b1, 5'd12, 8'h77);
    @(negedge clk);
    req_valid = 1'b0;
    check("x_read_pre",  32'(read), 32'd1);
    check("x_level_pre", 32'(fifo_level), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("x_read",      32'(read), 32'd0);
    check("x_write",     32'(write), 32'd0);
    check("x_rsp_valid", 32'(rsp_valid), 32'd0);
    check("x_level",     32'(fifo_level), 32'd0);
    check("x_busy",      32'(busy), 32'd0);
    check("x_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("x_no_stale", 32'(rsp_valid), 32'd0);
      check("x_no_write", 32'(write), 32'd0);
    end
    check("x_ready_back", 32'(req_ready), 32'd1);
    drive(1'b1, 5'd12, 8'h99);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("x_w_write", 32'(write), 32'd1);
    check("x_w_addr",  32'(addr), 32'd12);
    check("x_w_data",  32'(data_in), 32'h99);
    @(negedge clk);
    drive(1'b0, 5'd12, 8'h00);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("x_r_read", 32'(read), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("x_r_valid", 32'(rsp_valid), 32'd1);
    check("x_r_rdata", 32'(rsp_rdata), 32'h99);
    check("x_r_addr",  32'(rsp_addr), 32'd12);

    check("never_rd_and_wr", 32'(both_seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Request sequencer that sits directly upstream of the 32x8 synchronous memory (`mem`).
- Accepts read/write requests from a test or master over a valid/ready channel and buffers them in a small in-order FIFO.
- Drives the memory's `read`, `write`, `addr` and `data_in` pins one cycle per operation, captures `data_out` after the memory read latency, and returns read data over a valid/ready response channel.
- Guarantees `read` and `write` are never asserted together, and preserves request order.

Parameters:
- ADDR_W, 5, memory address width (32 locations).
- DATA_W, 8, memory data width.
- FIFO_DEPTH, 4, request FIFO entries; power of two, minimum 2.
- RD_LATENCY, 1, edges from the memory sampling `read` to `data_out` being valid.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  FIFO can accept a request.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  target address.
- req_wdata  input  DATA_W  write data; ignored for reads.
- rsp_valid  output  1  read data available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  DATA_W  read data.
- rsp_addr  output  ADDR_W  address the read data came from.
- read  output  1  to memory `read`.
- write  output  1  to memory `write`.
- addr  output  ADDR_W  to memory `addr`.
- data_in  output  DATA_W  to memory `data_in`.
- data_out  input  DATA_W  from memory `data_out`.
- fifo_level  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- busy  output  1  FIFO non-empty, or state is not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs go to 0 immediately: `read`, `write`, `addr`, `data_in`, `rsp_valid`, `rsp_rdata`, `rsp_addr`, `fifo_level`, `busy`.
  - `req_ready` is 0 while reset is asserted and 1 from the first cycle after release.
  - FIFO is emptied and state returns to IDLE.
  - Any in-flight read is discarded; no response is produced for it.
- Request push:
  - Occurs on an edge where req_valid && req_ready.
  - req_ready = !full. It is not combinationally dependent on a pop in the same cycle, so a full FIFO refuses a push even when popping.
- Memory-side outputs (`read`, `write`, `addr`, `data_in`) are registered, and each strobe is high for exactly one cycle per operation.
- FSM states: IDLE, RD_WAIT, RESP.
- IDLE:
  - Head is a write: pop it; drive write=1 with addr/data_in for the next cycle; stay in IDLE. Back-to-back writes issue one per cycle.
  - Head is a read: pop it; drive read=1 with addr; go to RD_WAIT.
  - FIFO empty: read = write = 0.
- RD_WAIT:
  - Count RD_LATENCY+1 edges from the read strobe.
  - With RD_LATENCY=1: read is high in cycle T, the memory samples it at edge T+1, and the controller captures data_out at edge T+2.
  - On capture, load rsp_rdata/rsp_addr, set rsp_valid=1, go to RESP.
  - The FIFO keeps accepting pushes during RD_WAIT.
- RESP:
  - Hold rsp_valid and data stable until rsp_valid && rsp_ready.
  - A head write may issue during RESP; ordering is safe because the read has already completed.
  - A head read stalls until the response is accepted.
  - On acceptance: rsp_valid=0 next cycle; go to IDLE. A head read may issue in that same cycle.
- Simultaneous push and pop on a non-full FIFO: both occur and fifo_level is unchanged.
- Empty FIFO with a push: the entry becomes visible at the head the following cycle (no fall-through).
- Pointers: ($clog2(FIFO_DEPTH))-bit values wrapping modulo FIFO_DEPTH; full/empty derived from fifo_level.
- Write followed by read to the same address returns the new data, since writes issue strictly in order.

Decomposition:
- mem_ctrl_pkg holds:
  - ADDR_W and DATA_W defaults.
  - typedef mem_req_t struct {logic write; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata;}.
  - typedef enum {IDLE, RD_WAIT, RESP} ctrl_state_e.
- One sub-module: mem_req_fifo, a synchronous FIFO of mem_req_t with FIFO_DEPTH entries and push/pop/full/empty/level. mem_req_ctrl instantiates it and holds the FSM and response register.

Test Plan:
- Reset then single write addr=5 data=8'hA5 -> write=1, addr=5, data_in=A5 for exactly one cycle, 2 cycles after acceptance; read stays 0.
- Write addr=5 A5 then read addr=5 with rsp_ready=1 -> rsp_valid=1 with rsp_rdata=A5, rsp_addr=5; never read&&write; rsp_valid arrives 2 edges after read strobe.
- Push 5 requests back-to-back with no pops possible (hold a read response with rsp_ready=0) -> req_ready drops when fifo_level=4; the 5th is held until space frees.
- Read addr=31 with rsp_ready=0 for 10 cycles, followed by writes to addr 0..2 -> response held stable for 10 cycles; the three writes issue during RESP; a following read waits for acceptance.
- Wrap-around: 12 alternating writes/reads over addresses 0..31 -> all read data matches the scoreboard; pointers wrap cleanly.
- Assert rst_n=0 during RD_WAIT -> read/write/rsp_valid go 0 immediately, fifo_level=0; after release, no stale response and the next write behaves normally.
